interval_down_counter: RTL and testbench



---
 rtl/interval_down_counter_pkg.sv | 16 +
 rtl/interval_down_counter_tick_prescaler.sv | 38 +++
 rtl/interval_down_counter.sv | 98 +++++++++
 tb/tb_interval_down_counter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/interval_down_counter_pkg.sv
// Shared types and default sizes for the interval timers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package interval_down_counter_pkg;

   // Timer FSM: IDLE holds the count, RUN decrements on prescaled ticks.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Default sizes, shared with the free-running up-counter.
   localparam int DEF_WIDTH      = 8;
   localparam int DEF_PRESCALE_W = 4;

endpackage : interval_down_counter_pkg

// File: rtl/interval_down_counter_tick_prescaler.sv
// Tick divider: emits tick every prescale_i+1 enabled cycles.
// Latency: tick is combinational from the registered count and prescale_i.
// Backpressure: none; enable_i low freezes the count, clear_i restarts it.
module tick_prescaler
   import interval_down_counter_pkg::*;
#(
   parameter int PRESCALE_W = DEF_PRESCALE_W
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  clear_i,
   input  logic                  enable_i,
   input  logic [PRESCALE_W-1:0] prescale_i,
   output logic                  tick_o
);

   logic [PRESCALE_W-1:0] cnt_q, cnt_d;

   // Compare against the live prescale so a mid-run change applies at once.
   assign tick_o = enable_i && (cnt_q >= prescale_i);

   // Next count: clear wins, otherwise wrap on tick or advance while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = tick_o ? '0 : cnt_q + 1'b1;
      end
   end

   // Prescaler count register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule : tick_prescaler

// File: rtl/interval_down_counter.sv
// Programmable down-counting interval timer with tc pulse, sticky irq, auto-reload.
// Latency: all outputs registered; expiry N*(prescale+1) enabled cycles after load.
// Backpressure: none; enable_i low pauses count and prescaler, load_i always wins.
module interval_down_counter
   import interval_down_counter_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int PRESCALE_W = DEF_PRESCALE_W
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  load_i,
   input  logic [WIDTH-1:0]      load_value_i,
   input  logic                  enable_i,
   input  logic                  auto_reload_i,
   input  logic [PRESCALE_W-1:0] prescale_i,
   input  logic                  irq_clear_i,
   output logic [WIDTH-1:0]      value_o,
   output logic                  running_o,
   output logic                  tc_o,
   output logic                  irq_o
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             tc_q, tc_d;
   logic             irq_q, irq_d;
   logic             presc_en;
   logic             tick;

   // Prescaler only runs in RUN; a load restarts its phase.
   assign presc_en = (state_q == ST_RUN) && enable_i && !load_i;

   tick_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .clear_i    (load_i),
      .enable_i   (presc_en),
      .prescale_i (prescale_i),
      .tick_o     (tick)
   );

   // Next state: load beats counting; expiry pulses tc, sets irq, reloads or stops.
   always_comb begin
      state_d  = state_q;
      value_d  = value_q;
      reload_d = reload_q;
      tc_d     = 1'b0;
      irq_d    = irq_q && !irq_clear_i;
      if (load_i) begin
         value_d  = load_value_i;
         reload_d = load_value_i;
         state_d  = (load_value_i != '0) ? ST_RUN : ST_IDLE;
      end else if (state_q == ST_RUN && tick) begin
         if (value_q > ONE) begin
            value_d = value_q - ONE;
         end else begin
            // Expiry; irq set overrides a simultaneous clear.
            tc_d  = 1'b1;
            irq_d = 1'b1;
            if (auto_reload_i && reload_q != '0) begin
               value_d = reload_q;
            end else begin
               value_d = '0;
               state_d = ST_IDLE;
            end
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= ST_IDLE;
         value_q  <= '0;
         reload_q <= '0;
         tc_q     <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         value_q  <= value_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
         irq_q    <= irq_d;
      end
   end

   assign value_o   = value_q;
   assign running_o = (state_q == ST_RUN);
   assign tc_o      = tc_q;
   assign irq_o     = irq_q;

endmodule : interval_down_counter

// File: tb/tb_interval_down_counter.sv
// Directed self-checking bench for interval_down_counter.
// Inputs change 1ns after each rising edge; outputs are sampled at the same point.
module tb_interval_down_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       load;
   logic [7:0] load_value;
   logic       enable;
   logic       auto_reload;
   logic [3:0] prescale;
   logic       irq_clear;
   logic [7:0] value;
   logic       running;
   logic       tc;
   logic       irq;

   int tests = 0;
   int fails = 0;

   interval_down_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .load_i        (load),
      .load_value_i  (load_value),
      .enable_i      (enable),
      .auto_reload_i (auto_reload),
      .prescale_i    (prescale),
      .irq_clear_i   (irq_clear),
      .value_o       (value),
      .running_o     (running),
      .tc_o          (tc),
      .irq_o         (irq)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [7:0] v);
      load = 1'b1; load_value = v;
      step();
      load = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; load = 0; load_value = 0; enable = 0; auto_reload = 0;
      prescale = 0; irq_clear = 0;
      step(); step();
      reset = 1'b0;
      step();
      tests++;
      if ({value, running, tc, irq} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset: value=%0d running=%b tc=%b irq=%b, want 0 0 0 0", value, running, tc, irq);
      end
   endtask

   task automatic test_oneshot();
      logic [7:0] exp_v [5];
      exp_v = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
      enable = 1; prescale = 0; auto_reload = 0;
      do_load(8'd5);
      tests++;
      if (value !== 8'd5 || running !== 1'b1) begin
         fails++;
         $display("FAIL oneshot_load: value=%0d running=%b, want 5 1", value, running);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         tests++;
         if (value !== exp_v[i] || tc !== (i == 4)) begin
            fails++;
            $display("FAIL oneshot_step%0d: value=%0d tc=%b, want %0d %b", i, value, tc, exp_v[i], (i == 4));
         end
      end
      step();
      tests++;
      if (value !== 8'd0 || tc !== 1'b0 || irq !== 1'b1 || running !== 1'b0) begin
         fails++;
         $display("FAIL oneshot_after: value=%0d tc=%b irq=%b running=%b, want 0 0 1 0", value, tc, irq, running);
      end
   endtask

   task automatic test_auto_reload();
      int t;
      logic [7:0] ev;
      logic       et;
      irq_clear = 1; step(); irq_clear = 0;
      prescale = 2; auto_reload = 1; enable = 1;
      do_load(8'd3);
      for (int k = 1; k <= 18; k++) begin
         step();
         t  = k / 3;
         ev = 8'(3 - (t % 3));
         et = (k % 9 == 0);
         tests++;
         if (value !== ev || tc !== et || running !== 1'b1) begin
            fails++;
            $display("FAIL autoreload_c%0d: value=%0d tc=%b running=%b, want %0d %b 1", k, value, tc, running, ev, et);
         end
      end
      tests++;
      if (irq !== 1'b1) begin
         fails++;
         $display("FAIL autoreload_irq: irq=%b, want 1", irq);
      end
   endtask

   task automatic test_enable_pause();
      prescale = 0; auto_reload = 0; enable = 1;
      do_load(8'd4);
      step(); step();
      tests++;
      if (value !== 8'd2) begin
         fails++;
         $display("FAIL pause_pre: value=%0d, want 2", value);
      end
      enable = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         tests++;
         if (value !== 8'd2 || running !== 1'b1 || tc !== 1'b0) begin
            fails++;
            $display("FAIL pause_hold%0d: value=%0d running=%b tc=%b, want 2 1 0", i, value, running, tc);
         end
      end
      enable = 1;
      step();
      tests++;
      if (value !== 8'd1 || tc !== 1'b0) begin
         fails++;
         $display("FAIL pause_resume1: value=%0d tc=%b, want 1 0", value, tc);
      end
      step();
      tests++;
      if (value !== 8'd0 || tc !== 1'b1) begin
         fails++;
         $display("FAIL pause_resume0: value=%0d tc=%b, want 0 1", value, tc);
      end
   endtask

   task automatic test_irq_clear_race();
      irq_clear = 1; step(); irq_clear = 0;
      tests++;
      if (irq !== 1'b0) begin
         fails++;
         $display("FAIL irqclr_pre: irq=%b, want 0", irq);
      end
      prescale = 0; auto_reload = 0; enable = 1;
      do_load(8'd2);
      step();
      irq_clear = 1;
      step();
      irq_clear = 0;
      tests++;
      if (irq !== 1'b1 || tc !== 1'b1 || value !== 8'd0) begin
         fails++;
         $display("FAIL irqclr_race: irq=%b tc=%b value=%0d, want 1 1 0", irq, tc, value);
      end
      step();
      tests++;
      if (irq !== 1'b1) begin
         fails++;
         $display("FAIL irqclr_sticky: irq=%b, want 1", irq);
      end
      irq_clear = 1; step(); irq_clear = 0;
      tests++;
      if (irq !== 1'b0) begin
         fails++;
         $display("FAIL irqclr_lone: irq=%b, want 0", irq);
      end
   endtask

   task automatic test_load_on_expiry();
      prescale = 0; auto_reload = 0; enable = 1;
      do_load(8'd1);
      do_load(8'd7);
      tests++;
      if (value !== 8'd7 || tc !== 1'b0 || irq !== 1'b0 || running !== 1'b1) begin
         fails++;
         $display("FAIL load_expiry: value=%0d tc=%b irq=%b running=%b, want 7 0 0 1", value, tc, irq, running);
      end
   endtask

   task automatic test_load_zero();
      do_load(8'd0);
      tests++;
      if (value !== 8'd0 || running !== 1'b0 || tc !== 1'b0) begin
         fails++;
         $display("FAIL load_zero: value=%0d running=%b tc=%b, want 0 0 0", value, running, tc);
      end
      step();
      tests++;
      if (tc !== 1'b0 || value !== 8'd0) begin
         fails++;
         $display("FAIL load_zero_idle: tc=%b value=%0d, want 0 0", tc, value);
      end
   endtask

   task automatic test_prescale_change();
      prescale = 7; enable = 1; auto_reload = 0;
      do_load(8'd5);
      step(); step();
      tests++;
      if (value !== 8'd5) begin
         fails++;
         $display("FAIL presc_hold: value=%0d, want 5", value);
      end
      prescale = 1;
      step();
      tests++;
      if (value !== 8'd4) begin
         fails++;
         $display("FAIL presc_change: value=%0d, want 4", value);
      end
   endtask

   task automatic test_reset_midrun();
      prescale = 0; enable = 1; auto_reload = 0;
      do_load(8'd1);
      step();
      do_load(8'h80);
      tests++;
      if (value !== 8'h80 || running !== 1'b1 || irq !== 1'b1) begin
         fails++;
         $display("FAIL rst_mid_pre: value=%0h running=%b irq=%b, want 80 1 1", value, running, irq);
      end
      reset = 1;
      step();
      reset = 0;
      tests++;
      if ({value, running, tc, irq} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL rst_mid: value=%0h running=%b tc=%b irq=%b, want 0 0 0 0", value, running, tc, irq);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         tests++;
         if (tc !== 1'b0 || value !== 8'd0 || running !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_after%0d: tc=%b value=%0d running=%b, want 0 0 0", i, tc, value, running);
         end
      end
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_auto_reload();
      test_enable_pause();
      test_irq_clear_race();
      test_load_on_expiry();
      test_load_zero();
      test_prescale_change();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_interval_down_counter
